// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
// Job-level sequencer that emits the instruction word for one complete tile:
// weight fetch into L0, kernel load, activation fetch, execute, OFIFO drain
// into psum SRAM, then SFU accumulate and optional ReLU readout.
//
// Ports
//   clk, reset        : clock, synchronous active-low reset (0 = reset)
//   start             : job request, accepted only in IDLE
//   cfg_w_base        : xmem base address of the weights
//   cfg_a_base        : xmem base address of the activations
//   cfg_p_base        : pmem base address
//   cfg_n_act         : number of activation vectors (0 = empty job)
//   cfg_simd, cfg_op_mode, cfg_ld_mode, cfg_acc, cfg_relu : mode bits
//   ofifo_valid       : core output FIFO has data
//   inst              : registered instruction word to core
//   busy              : high in any state other than IDLE
//   done              : one-cycle pulse in the DONE state
//   err               : drain timeout, sticky until the next accepted start
//   state_dbg         : current FSM state, for checkers
//
// Handshake: start is a level sampled at each rising edge while IDLE; the
// first edge that sees start=1 accepts the job and captures every cfg_* input.
// start seen while busy is dropped, never queued.
module core_seq_ctrl #(
  parameter int row           = 8,
  parameter int col           = 8,
  parameter int inst_bw       = 39,
  parameter int ADDR_W        = 11,
  parameter int CNT_W         = 11,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_w_base,
  input  logic [ADDR_W-1:0]  cfg_a_base,
  input  logic [ADDR_W-1:0]  cfg_p_base,
  input  logic [CNT_W-1:0]   cfg_n_act,
  input  logic               cfg_simd,
  input  logic               cfg_op_mode,
  input  logic               cfg_ld_mode,
  input  logic               cfg_acc,
  input  logic               cfg_relu,
  input  logic               ofifo_valid,
  output logic [inst_bw-1:0] inst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         state_dbg
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [inst_bw-1:0] IDLE_WORD  = inst_bw'(39'h01800C0000);
  localparam logic [CNT_W-1:0]   ROW_LAST   = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0]   KLOAD_LAST = CNT_W'(row + col - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WFETCH, S_WFLUSH, S_KLOAD, S_AFETCH, S_AFLUSH,
    S_EXEC, S_DRAIN, S_SFU, S_SFLUSH, S_RELU, S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] p_base;
    logic [CNT_W-1:0]  n_act;
    logic              simd;
    logic              op_mode;
    logic              ld_mode;
    logic              acc;
    logic              relu;
  } cfg_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic               err_q, err_d;
  cfg_t               cfg_q, cfg_d;
  logic [inst_bw-1:0] inst_q, inst_d;

  // Fields of the word for the next cycle.
  logic              cen_x, cen_p, wen_p;
  logic [ADDR_W-1:0] ax, ap;
  logic              l0_rd, l0_wr, execute, load, ofifo_rd, acc, sfu_acc, sfu_relu;
  logic              mode_on;

  // The whole next word is decided from registered state and cfg, so inst
  // leaves a flop. ofifo_valid is only sampled at the edge into that flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    err_d    = err_q;
    cfg_d    = cfg_q;
    cen_x    = 1'b1;
    ax       = '0;
    cen_p    = 1'b1;
    wen_p    = 1'b1;
    ap       = '0;
    l0_rd    = 1'b0;
    execute  = 1'b0;
    load     = 1'b0;
    ofifo_rd = 1'b0;
    acc      = 1'b0;
    sfu_relu = 1'b0;
    // Read data lands one cycle after the address cycle, so the write/acc
    // strobe is the previous cycle's read strobe carried through inst_q.
    l0_wr    = (state_q == S_WFETCH) || (state_q == S_AFETCH);
    sfu_acc  = (state_q == S_SFU);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d  = '{w_base: cfg_w_base, a_base: cfg_a_base, p_base: cfg_p_base,
                     n_act: cfg_n_act, simd: cfg_simd, op_mode: cfg_op_mode,
                     ld_mode: cfg_ld_mode, acc: cfg_acc, relu: cfg_relu};
          err_d  = 1'b0;
          cnt_d  = '0;
          idle_d = '0;
          if (cfg_n_act != '0) begin
            state_d = S_WFETCH;
            cen_x   = 1'b0;
            ax      = cfg_w_base;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WFETCH: begin
        if (cnt_q == ROW_LAST) begin
          state_d = S_WFLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cen_x = 1'b0;
          ax    = cfg_q.w_base + ADDR_W'(cnt_d);
        end
      end
      S_WFLUSH: begin
        state_d = S_KLOAD;
        cnt_d   = '0;
        l0_rd   = 1'b1;
        load    = 1'b1;
      end
      S_KLOAD: begin
        cnt_d = '0;
        if (cnt_q == KLOAD_LAST) begin
          state_d = S_AFETCH;
          cen_x   = 1'b0;
          ax      = cfg_q.a_base;
        end else begin
          cnt_d = cnt_q + 1'b1;
          l0_rd = 1'b1;
          load  = 1'b1;
        end
      end
      S_AFETCH: begin
        if (cnt_q == cfg_q.n_act - 1'b1) begin
          state_d = S_AFLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cen_x = 1'b0;
          ax    = cfg_q.a_base + ADDR_W'(cnt_d);
        end
      end
      S_AFLUSH: begin
        state_d = S_EXEC;
        cnt_d   = '0;
        l0_rd   = 1'b1;
        execute = 1'b1;
      end
      S_EXEC: begin
        if (cnt_q == cfg_q.n_act - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          l0_rd   = 1'b1;
          execute = 1'b1;
        end
      end
      S_DRAIN: begin
        // cnt_q is k, the number of pmem writes issued so far.
        if (cnt_q == cfg_q.n_act) begin
          state_d = S_SFU;
          cnt_d   = '0;
          cen_p   = 1'b0;
          ap      = cfg_q.p_base;
        end else if (ofifo_valid) begin
          idle_d   = '0;
          ofifo_rd = 1'b1;
          cen_p    = 1'b0;
          wen_p    = 1'b0;
          ap       = cfg_q.p_base + ADDR_W'(cnt_q);
          acc      = cfg_q.acc;
          cnt_d    = cnt_q + 1'b1;
        end else if (idle_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_SFU: begin
        if (cnt_q == cfg_q.n_act - 1'b1) begin
          state_d = S_SFLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cen_p = 1'b0;
          ap    = cfg_q.p_base + ADDR_W'(cnt_d);
        end
      end
      S_SFLUSH: begin
        if (cfg_q.relu) begin
          state_d  = S_RELU;
          sfu_relu = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RELU:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE drives the plain idle word, mode bits included.
    mode_on = (state_d != S_IDLE) && (state_d != S_DONE);
    inst_d  = inst_bw'({mode_on & cfg_d.simd, sfu_relu, sfu_acc,
                        mode_on & cfg_d.ld_mode, mode_on & cfg_d.op_mode, acc,
                        cen_p, wen_p, ap, cen_x, 1'b1, ax,
                        ofifo_rd, 2'b00, l0_rd, l0_wr, execute, load});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      cfg_q   <= '0;
      inst_q  <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      cfg_q   <= cfg_d;
      inst_q  <= inst_d;
    end
  end

  assign inst      = inst_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl
// Directed bench for core_seq_ctrl. A table of per-cycle records covers one
// full tile (row=8, col=8, n_act=4) plus a back-to-back empty job; hand
// sequences cover drain timeout and reset in the middle of KLOAD.
module tb_core_seq_ctrl;

  localparam logic [38:0] IDLE_W = 39'h01800C0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cfg_w_base = '0, cfg_a_base = '0, cfg_p_base = '0;
  logic [10:0] cfg_n_act = '0;
  logic        cfg_simd = 1'b0, cfg_op_mode = 1'b0, cfg_ld_mode = 1'b0;
  logic        cfg_acc = 1'b0, cfg_relu = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [38:0] inst;
  logic        busy, done, err;
  logic [3:0]  state_dbg;

  core_seq_ctrl #(.DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_p_base(cfg_p_base),
    .cfg_n_act(cfg_n_act), .cfg_simd(cfg_simd), .cfg_op_mode(cfg_op_mode),
    .cfg_ld_mode(cfg_ld_mode), .cfg_acc(cfg_acc), .cfg_relu(cfg_relu),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        start;
    logic        ofv;
    logic [38:0] exp_inst;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [38:0] exp_q[$];   // expected pmem write addresses, in order

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_val(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                         input logic [10:0] n, input logic simd, input logic op,
                         input logic ld, input logic acc, input logic relu);
    cfg_w_base = w; cfg_a_base = a; cfg_p_base = p; cfg_n_act = n;
    cfg_simd = simd; cfg_op_mode = op; cfg_ld_mode = ld; cfg_acc = acc; cfg_relu = relu;
  endtask

  // Drive start in cycle 0; returns in cycle 1 with start dropped.
  task automatic start_job();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    vec_t        v;
    logic [38:0] m, w;
    logic [5:0]  pat;
    int          k;
    int          wr_cnt;

    // Main tile: simd=1, ld_mode=1, op_mode=0, acc=1, relu=1.
    m = IDLE_W;
    m[38] = 1'b1;
    m[35] = 1'b1;
    pat = 6'b101101;   // ofifo_valid in cycles 35..40, MSB first
    k = 0;
    for (int t = 1; t <= 51; t++) begin
      v.cyc      = t;
      v.start    = (t == 5) || (t == 20) || (t == 49);
      v.ofv      = (t >= 35 && t <= 40) ? pat[5 - (t - 35)] : 1'b0;
      v.exp_busy = (t <= 48) || (t == 50);
      v.exp_done = (t == 48) || (t == 50);
      v.exp_err  = 1'b0;
      w = (t <= 47) ? m : IDLE_W;
      if (t >= 1 && t <= 8) begin
        w[19]   = 1'b0;
        w[17:7] = 11'h010 + 11'(t - 1);
      end
      if (t >= 26 && t <= 29) begin
        w[19]   = 1'b0;
        w[17:7] = 11'h7FE + 11'(t - 26);
      end
      if ((t >= 2 && t <= 9) || (t >= 27 && t <= 30)) w[2] = 1'b1;
      if (t >= 10 && t <= 25) begin w[3] = 1'b1; w[0] = 1'b1; end
      if (t >= 31 && t <= 34) begin w[3] = 1'b1; w[1] = 1'b1; end
      if (t == 36 || t == 38 || t == 39 || t == 41) begin
        w[33] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[6] = 1'b1;
        w[30:20] = 11'h100 + 11'(k);
        exp_q.push_back(39'(11'h100 + 11'(k)));
        k++;
      end
      if (t >= 42 && t <= 45) begin
        w[32]    = 1'b0;
        w[30:20] = 11'h100 + 11'(t - 42);
      end
      if (t >= 43 && t <= 46) w[36] = 1'b1;
      if (t == 47) w[37] = 1'b1;
      v.exp_inst = w;
      vecs.push_back(v);
    end

    // Reset values.
    reset = 1'b0;
    repeat (3) tick();
    check_val("rst_inst", inst, IDLE_W);
    check_val("rst_busy", 39'(busy), 39'd0);
    check_val("rst_done", 39'(done), 39'd0);
    check_val("rst_err", 39'(err), 39'd0);
    reset = 1'b1;
    tick();

    // Full tile from the table.
    set_cfg(11'h010, 11'h7FE, 11'h100, 11'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    start_job();
    // Inputs change after capture; the job must keep the captured values and
    // the trailing empty job (start in cycle 49) picks up n_act=0.
    set_cfg(11'h3AA, 11'h155, 11'h002, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      check_val("tbl_inst", inst, vecs[i].exp_inst);
      check_val("tbl_busy", 39'(busy), 39'(vecs[i].exp_busy));
      check_val("tbl_done", 39'(done), 39'(vecs[i].exp_done));
      check_val("tbl_err", 39'(err), 39'(vecs[i].exp_err));
      if (inst[32] === 1'b0 && inst[31] === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pmem_wr_extra cyc=%0d actual_addr=%h required=none", cyc, inst[30:20]);
        end else begin
          check_val("pmem_wr_addr", 39'(inst[30:20]), exp_q.pop_front());
        end
      end
      start       = vecs[i].start;
      ofifo_valid = vecs[i].ofv;
      tick();
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    check_val("pmem_wr_left", 39'(exp_q.size()), 39'd0);

    // Drain timeout: n_act=2, ofifo_valid held low. DRAIN spans cycles
    // 31..46, DONE with err in cycle 47.
    set_cfg(11'h000, 11'h000, 11'h020, 11'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_job();
    wr_cnt = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (inst[31] === 1'b0) wr_cnt++;
      tick();
    end
    check_val("to_done_cycle", 39'(cyc), 39'd47);
    check_val("to_err", 39'(err), 39'd1);
    check_val("to_no_writes", 39'(wr_cnt), 39'd0);
    tick();
    check_val("to_busy_low", 39'(busy), 39'd0);
    check_val("to_err_sticky", 39'(err), 39'd1);
    tick();
    check_val("to_err_sticky2", 39'(err), 39'd1);

    // Reset in mid-KLOAD; the new start also clears the sticky err.
    set_cfg(11'h010, 11'h7FE, 11'h100, 11'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    start_job();
    check_val("restart_err_clr", 39'(err), 39'd0);
    while (cyc < 15) tick();
    check_val("kload_load", 39'(inst[3:0]), 39'h9);
    reset = 1'b0;
    tick();
    check_val("mid_rst_inst", inst, IDLE_W);
    check_val("mid_rst_busy", 39'(busy), 39'd0);
    check_val("mid_rst_done", 39'(done), 39'd0);
    tick();
    check_val("mid_rst_inst2", inst, IDLE_W);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("post_rst_inst", inst, IDLE_W);
      check_val("post_rst_busy", 39'(busy), 39'd0);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
